// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit with HI/LO pair and pipeline stall
module ex_muldiv_sequencer #(
    parameter int BITS_SIZE  = 32,
    parameter int BITS_COUNT = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [1:0]           i_md_op,
    input  logic [BITS_SIZE-1:0] i_data_a,
    input  logic [BITS_SIZE-1:0] i_data_b,
    input  logic                 i_rd_hilo,
    input  logic                 i_wr_hi,
    input  logic                 i_wr_lo,
    output logic [BITS_SIZE-1:0] o_hi,
    output logic [BITS_SIZE-1:0] o_lo,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_div_zero,
    output logic                 o_stall
);
    localparam int W = BITS_SIZE;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [BITS_COUNT-1:0] cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [W-1:0]         m_q, m_d;
    logic [2*W-1:0]       p_q, p_d;
    logic [W-1:0]         araw_q, araw_d;
    logic                 neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d, div_zero_q, div_zero_d;

    logic [W-1:0]   abs_a, abs_b, quo, rem, fix_hi, fix_lo;
    logic [W:0]     add, r_sh, trial;
    logic [2*W-1:0] mul_nx, div_nx, prod;
    logic           start_div;

    // One iteration of shift-add multiply or restoring divide, plus sign fix-up of the result
    always_comb begin
        abs_a     = (i_md_op[0] & i_data_a[W-1]) ? -i_data_a : i_data_a;
        abs_b     = (i_md_op[0] & i_data_b[W-1]) ? -i_data_b : i_data_b;
        start_div = i_md_op[1];
        add       = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
        mul_nx    = {add, p_q[W-1:1]};
        r_sh      = p_q[2*W-1:W-1];
        trial     = r_sh - {1'b0, m_q};
        div_nx    = trial[W] ? {r_sh[W-1:0], p_q[W-2:0], 1'b0} : {trial[W-1:0], p_q[W-2:0], 1'b1};
        prod      = (op_q[0] & neg_q_q) ? -p_q : p_q;
        quo       = (op_q[0] & neg_q_q) ? -p_q[W-1:0] : p_q[W-1:0];
        rem       = (op_q[0] & neg_r_q) ? -p_q[2*W-1:W] : p_q[2*W-1:W];
        fix_hi    = op_q[1] ? (dz_q ? araw_q : rem) : prod[2*W-1:W];
        fix_lo    = op_q[1] ? (dz_q ? {W{1'b1}} : quo) : prod[W-1:0];
    end

    // Next-state: operand capture in IDLE, iteration in CALC, HI/LO write-back in FIX
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        m_d        = m_q;
        p_d        = p_q;
        araw_d     = araw_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = state_q == S_FIX;
        div_zero_d = (state_q == S_FIX) & dz_q;
        if (state_q == S_IDLE) begin
            hi_d = i_wr_hi ? i_data_a : hi_q;
            lo_d = i_wr_lo ? i_data_a : lo_q;
            if (i_start) begin
                state_d = S_CALC;
                cnt_d   = '0;
                op_d    = i_md_op;
                m_d     = start_div ? abs_b : abs_a;
                p_d     = {{W{1'b0}}, start_div ? abs_a : abs_b};
                araw_d  = i_data_a;
                neg_q_d = i_data_a[W-1] ^ i_data_b[W-1];
                neg_r_d = i_data_a[W-1];
                dz_d    = start_div & (i_data_b == '0);
            end
        end else if (state_q == S_CALC) begin
            p_d     = op_q[1] ? div_nx : mul_nx;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == BITS_COUNT'(W-1)) ? S_FIX : S_CALC;
        end else begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            state_d = S_IDLE;
        end
    end

    // State and datapath registers; reset aborts any operation and clears HI/LO
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            m_q        <= '0;
            p_q        <= '0;
            araw_q     <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            m_q        <= m_d;
            p_q        <= p_d;
            araw_q     <= araw_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign o_hi       = hi_q;
    assign o_lo       = lo_q;
    assign o_busy     = state_q != S_IDLE;
    assign o_done     = done_q;
    assign o_div_zero = div_zero_q;
    assign o_stall    = o_busy & (i_start | i_rd_hilo | i_wr_hi | i_wr_lo);
endmodule
